baccarat_match_controller: RTL and testbench
============================================

Name: baccarat_match_controller

Overview:
Parametrised successor to the single-hand baccarat dealing FSM. It sequences multiple rounds of a match and requests each card from the card source through a req/ack handshake instead of one card per clock. It shows a distinct tie light, keeps per-match win/tie tallies and a round counter, and declares a match winner after MAX_ROUNDS. It sits between the card/score datapath (which owns the hand registers and score adders) and the board LEDs/HEX decoders.

Parameters:
MAX_ROUNDS, 9, rounds per match (1..15)
TALLY_W, 4, width of each win/tie tally; tallies saturate at 2^TALLY_W-1
NATURAL_MIN, 8, two-card score at or above which the hand is a natural

Ports:
slow_clock  input  1  system clock; all state on rising edge
resetb  input  1  asynchronous reset, active-high (port keeps the codebase name)
start  input  1  begin first round from IDLE
next_round  input  1  advance from SHOW to the next round
new_match  input  1  synchronous abort: clear tallies/counter, go to IDLE
card_ack  input  1  card source has a card on the bus this cycle
pscore  input  4  player hand score 0..9 from datapath
dscore  input  4  dealer hand score 0..9 from datapath
pcard3  input  4  player third card value 0..9 (face cards already mapped to 0)
card_req  output  1  requesting a card
load_pcard1..3, load_dcard1..3  output  1 each  datapath load strobes
clear_hands  output  1  one-cycle pulse clearing datapath hands
player_win_light, dealer_win_light, tie_light  output  1 each  result lights
player_tally, dealer_tally, tie_tally  output  TALLY_W each
round_count  output  $clog2(MAX_ROUNDS+1)  rounds completed
match_over  output  1  high in DONE

Behaviour:
- Reset (async, resetb=1): state IDLE; all tallies, round_count and lights 0; combinational outputs evaluate to 0.
- States: IDLE, P1, D1, P2, D2, CHECK, P3, BDEC, D3, SCORE, SHOW, DONE.
- Deal states (P1, D1, P2, D2, P3, D3):
  - card_req=1.
  - Matching load_* = card_req & card_ack, combinational, same cycle.
  - Advance on the edge where card_ack=1; otherwise stall indefinitely.
  - Order: P1→D1→P2→D2→CHECK.
  - card_ack outside deal states is ignored.
- CHECK (scores reflect 4 cards):
  - pscore or dscore ≥ NATURAL_MIN → SCORE.
  - Else pscore ≤ 5 → P3.
  - Else dscore ≤ 5 → D3.
  - Else → SCORE.
- P3→BDEC after ack. BDEC: banker draws (→D3) if any of the following, else → SCORE:
  - dscore ≤ 2;
  - dscore=3 and pcard3≠8;
  - dscore=4 and pcard3∈2..7;
  - dscore=5 and pcard3∈4..7;
  - dscore=6 and pcard3∈6..7.
- D3→SCORE after ack.
- SCORE (1 cycle):
  - Register exactly one of player/dealer/tie light (pscore>dscore / < / =).
  - Increment the matching tally, saturating.
  - round_count+1.
  - → SHOW.
- SHOW: lights held.
  - On next_round: if round_count==MAX_ROUNDS → DONE; else clear_hands=1 that cycle, lights cleared, → P1.
- DONE: match_over=1.
  - Lights show the match result: larger of player_tally/dealer_tally; equal → tie_light only.
  - Stays until new_match.
- IDLE: on start, clear_hands=1 that cycle, → P1.
  - next_round in IDLE is ignored.
- new_match, any state, highest priority:
  - Next state IDLE; tallies, round_count and lights cleared; clear_hands=1 that cycle.
  - Wins over simultaneous card_ack: no load strobe that cycle.
  - Wins over next_round and start.
- Illegal state encoding → IDLE.

Decomposition:
- baccarat_pkg: state enum, NATURAL_MIN default, PLAYER_STAND=5, BANKER_STAND=6 constants.
- One combinational sub-module, banker_draw_rule (dscore, pcard3 → draw), instantiated for BDEC.

Test Plan:
- start, ack every cycle; pscore=8/dscore=3 at CHECK → P1,D1,P2,D2 strobes in order, SCORE, player_win_light=1, player_tally=1, round_count=1, no P3 strobe.
- ack held low 5 cycles in D1 → card_req=1 throughout, no load strobes, state holds; ack on cycle 6 → single load_dcard1 pulse.
- pscore=4, dscore=3, pcard3=8 → load_pcard3 then SCORE without load_dcard3. Repeat with pcard3=7 → load_dcard3 issued.
- pscore=dscore=6 → no third cards, tie_light=1 only, tie_tally=1.
- MAX_ROUNDS=2: player wins both rounds → after second next_round, match_over=1, player_win_light=1.
- new_match asserted with card_ack in D2 → no load_dcard2, next state IDLE, tallies 0, clear_hands pulse; async resetb mid-P3 → all outputs 0 immediately.

Source files
------------

// File: rtl/baccarat_pkg.sv
// Shared types and constants for the multi-round baccarat match controller.
package baccarat_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_P1    = 4'd1,
        ST_D1    = 4'd2,
        ST_P2    = 4'd3,
        ST_D2    = 4'd4,
        ST_CHECK = 4'd5,
        ST_P3    = 4'd6,
        ST_BDEC  = 4'd7,
        ST_D3    = 4'd8,
        ST_SCORE = 4'd9,
        ST_SHOW  = 4'd10,
        ST_DONE  = 4'd11
    } state_t;

    localparam int NATURAL_MIN_DEFAULT = 8;

    localparam logic [3:0] PLAYER_STAND = 4'd5;
    localparam logic [3:0] BANKER_STAND = 4'd6;

endpackage

// File: rtl/banker_draw_rule.sv
// Banker third-card tableau: decides whether the banker draws after the
// player has taken a third card.
module banker_draw_rule
    import baccarat_pkg::*;
(
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       draw
);

    always_comb begin
        draw = 1'b0;
        if (dscore <= 4'd2) begin
            draw = 1'b1;
        end else if (dscore == 4'd3) begin
            draw = (pcard3 != 4'd8);
        end else if (dscore == 4'd4) begin
            draw = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
        end else if (dscore == 4'd5) begin
            draw = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
        end else if (dscore == BANKER_STAND) begin
            draw = (pcard3 >= 4'd6) && (pcard3 <= 4'd7);
        end
    end

endmodule

// File: rtl/baccarat_match_controller.sv
// Multi-round baccarat match sequencer: deals cards over a req/ack handshake,
// scores each round, keeps saturating tallies and declares the match winner.
module baccarat_match_controller
    import baccarat_pkg::*;
#(
    parameter int MAX_ROUNDS  = 9,
    parameter int TALLY_W     = 4,
    parameter int NATURAL_MIN = NATURAL_MIN_DEFAULT
) (
    input  logic                              slow_clock,
    input  logic                              resetb,
    input  logic                              start,
    input  logic                              next_round,
    input  logic                              new_match,
    input  logic                              card_ack,
    input  logic [3:0]                        pscore,
    input  logic [3:0]                        dscore,
    input  logic [3:0]                        pcard3,
    output logic                              card_req,
    output logic                              load_pcard1,
    output logic                              load_pcard2,
    output logic                              load_pcard3,
    output logic                              load_dcard1,
    output logic                              load_dcard2,
    output logic                              load_dcard3,
    output logic                              clear_hands,
    output logic                              player_win_light,
    output logic                              dealer_win_light,
    output logic                              tie_light,
    output logic [TALLY_W-1:0]                player_tally,
    output logic [TALLY_W-1:0]                dealer_tally,
    output logic [TALLY_W-1:0]                tie_tally,
    output logic [$clog2(MAX_ROUNDS+1)-1:0]   round_count,
    output logic                              match_over
);

    localparam int                RC_W      = $clog2(MAX_ROUNDS + 1);
    localparam logic [RC_W-1:0]   RC_MAX    = RC_W'(MAX_ROUNDS);
    localparam logic [TALLY_W-1:0] TALLY_MAX = '1;
    localparam logic [3:0]        NAT_MIN   = 4'(NATURAL_MIN);

    state_t state_q, state_d;
    logic   score_en;
    logic   lights_clr;
    logic   done_en;
    logic   natural;
    logic   bank_draw;

    banker_draw_rule u_banker_draw_rule (
        .dscore (dscore),
        .pcard3 (pcard3),
        .draw   (bank_draw)
    );

    assign natural = (pscore >= NAT_MIN) || (dscore >= NAT_MIN);

    always_ff @(posedge slow_clock or posedge resetb) begin
        if (resetb) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        card_req    = 1'b0;
        load_pcard1 = 1'b0;
        load_pcard2 = 1'b0;
        load_pcard3 = 1'b0;
        load_dcard1 = 1'b0;
        load_dcard2 = 1'b0;
        load_dcard3 = 1'b0;
        clear_hands = 1'b0;
        score_en    = 1'b0;
        lights_clr  = 1'b0;
        done_en     = 1'b0;
        match_over  = (state_q == ST_DONE);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    clear_hands = 1'b1;
                    state_d     = ST_P1;
                end
            end
            ST_P1: begin
                card_req = 1'b1;
                if (card_ack) begin
                    load_pcard1 = 1'b1;
                    state_d     = ST_D1;
                end
            end
            ST_D1: begin
                card_req = 1'b1;
                if (card_ack) begin
                    load_dcard1 = 1'b1;
                    state_d     = ST_P2;
                end
            end
            ST_P2: begin
                card_req = 1'b1;
                if (card_ack) begin
                    load_pcard2 = 1'b1;
                    state_d     = ST_D2;
                end
            end
            ST_D2: begin
                card_req = 1'b1;
                if (card_ack) begin
                    load_dcard2 = 1'b1;
                    state_d     = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (natural) begin
                    state_d = ST_SCORE;
                end else if (pscore <= PLAYER_STAND) begin
                    state_d = ST_P3;
                end else if (dscore < BANKER_STAND) begin
                    state_d = ST_D3;
                end else begin
                    state_d = ST_SCORE;
                end
            end
            ST_P3: begin
                card_req = 1'b1;
                if (card_ack) begin
                    load_pcard3 = 1'b1;
                    state_d     = ST_BDEC;
                end
            end
            ST_BDEC: begin
                state_d = bank_draw ? ST_D3 : ST_SCORE;
            end
            ST_D3: begin
                card_req = 1'b1;
                if (card_ack) begin
                    load_dcard3 = 1'b1;
                    state_d     = ST_SCORE;
                end
            end
            ST_SCORE: begin
                score_en = 1'b1;
                state_d  = ST_SHOW;
            end
            ST_SHOW: begin
                if (next_round) begin
                    if (round_count == RC_MAX) begin
                        done_en = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        clear_hands = 1'b1;
                        lights_clr  = 1'b1;
                        state_d     = ST_P1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort outranks everything, including a card arriving this cycle.
        if (new_match) begin
            state_d     = ST_IDLE;
            clear_hands = 1'b1;
            load_pcard1 = 1'b0;
            load_pcard2 = 1'b0;
            load_pcard3 = 1'b0;
            load_dcard1 = 1'b0;
            load_dcard2 = 1'b0;
            load_dcard3 = 1'b0;
            score_en    = 1'b0;
            lights_clr  = 1'b0;
            done_en     = 1'b0;
        end
    end

    always_ff @(posedge slow_clock or posedge resetb) begin
        if (resetb) begin
            player_win_light <= 1'b0;
            dealer_win_light <= 1'b0;
            tie_light        <= 1'b0;
            player_tally     <= '0;
            dealer_tally     <= '0;
            tie_tally        <= '0;
            round_count      <= '0;
        end else if (new_match) begin
            player_win_light <= 1'b0;
            dealer_win_light <= 1'b0;
            tie_light        <= 1'b0;
            player_tally     <= '0;
            dealer_tally     <= '0;
            tie_tally        <= '0;
            round_count      <= '0;
        end else if (score_en) begin
            round_count <= round_count + RC_W'(1);
            if (pscore > dscore) begin
                player_win_light <= 1'b1;
                dealer_win_light <= 1'b0;
                tie_light        <= 1'b0;
                if (player_tally != TALLY_MAX) begin
                    player_tally <= player_tally + TALLY_W'(1);
                end
            end else if (pscore < dscore) begin
                player_win_light <= 1'b0;
                dealer_win_light <= 1'b1;
                tie_light        <= 1'b0;
                if (dealer_tally != TALLY_MAX) begin
                    dealer_tally <= dealer_tally + TALLY_W'(1);
                end
            end else begin
                player_win_light <= 1'b0;
                dealer_win_light <= 1'b0;
                tie_light        <= 1'b1;
                if (tie_tally != TALLY_MAX) begin
                    tie_tally <= tie_tally + TALLY_W'(1);
                end
            end
        end else if (lights_clr) begin
            player_win_light <= 1'b0;
            dealer_win_light <= 1'b0;
            tie_light        <= 1'b0;
        end else if (done_en) begin
            // Match result: more round wins takes it, equal tallies light tie.
            player_win_light <= (player_tally > dealer_tally);
            dealer_win_light <= (player_tally < dealer_tally);
            tie_light        <= (player_tally == dealer_tally);
        end
    end

endmodule

// File: tb/tb_baccarat_match_controller.sv
// Directed bench for the baccarat match controller (two-round match, 1-bit tallies).
module tb_baccarat_match_controller;

    localparam int MAX_ROUNDS = 2;
    localparam int TALLY_W    = 1;

    localparam logic [11:0] REQ  = 12'b1000_0000_0000;
    localparam logic [11:0] L_P1 = 12'b0100_0000_0000;
    localparam logic [11:0] L_D1 = 12'b0010_0000_0000;
    localparam logic [11:0] L_P2 = 12'b0001_0000_0000;
    localparam logic [11:0] L_D2 = 12'b0000_1000_0000;
    localparam logic [11:0] L_P3 = 12'b0000_0100_0000;
    localparam logic [11:0] L_D3 = 12'b0000_0010_0000;
    localparam logic [11:0] CLR  = 12'b0000_0001_0000;
    localparam logic [11:0] PW   = 12'b0000_0000_1000;
    localparam logic [11:0] TL   = 12'b0000_0000_0010;
    localparam logic [11:0] MO   = 12'b0000_0000_0001;

    logic slow_clock, resetb, start, next_round, new_match, card_ack;
    logic [3:0] pscore, dscore, pcard3;
    logic card_req, load_pcard1, load_pcard2, load_pcard3;
    logic load_dcard1, load_dcard2, load_dcard3, clear_hands;
    logic player_win_light, dealer_win_light, tie_light, match_over;
    logic [TALLY_W-1:0] player_tally, dealer_tally, tie_tally;
    logic [1:0] round_count;

    logic [11:0] outs;
    logic [4:0]  cnt;
    int total = 0;
    int bad = 0;

    assign outs = {card_req, load_pcard1, load_dcard1, load_pcard2, load_dcard2,
                   load_pcard3, load_dcard3, clear_hands,
                   player_win_light, dealer_win_light, tie_light, match_over};
    assign cnt  = {player_tally, dealer_tally, tie_tally, round_count};

    baccarat_match_controller #(
        .MAX_ROUNDS  (MAX_ROUNDS),
        .TALLY_W     (TALLY_W),
        .NATURAL_MIN (8)
    ) dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .start            (start),
        .next_round       (next_round),
        .new_match        (new_match),
        .card_ack         (card_ack),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .card_req         (card_req),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .clear_hands      (clear_hands),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
        .tie_light        (tie_light),
        .player_tally     (player_tally),
        .dealer_tally     (dealer_tally),
        .tie_tally        (tie_tally),
        .round_count      (round_count),
        .match_over       (match_over)
    );

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    task automatic tick();
        @(posedge slow_clock);
        @(negedge slow_clock);
    endtask

    task automatic begin_round();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic deal4();
        card_ack = 1'b1;
        repeat (4) tick();
        card_ack = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        #1;
        total++; if (outs !== 12'b0) begin bad++; $display("FAIL reset_outs got=%b want=%b", outs, 12'b0); end
        total++; if (cnt !== 5'b0) begin bad++; $display("FAIL reset_cnt got=%b want=%b", cnt, 5'b0); end
        resetb = 1'b0; next_round = 1'b1; card_ack = 1'b1;
        tick(); #1;
        total++; if (outs !== 12'b0) begin bad++; $display("FAIL idle_ignore got=%b want=%b", outs, 12'b0); end
        next_round = 1'b0; card_ack = 1'b0;
    endtask

    task automatic test_natural();
        pscore = 4'd8; dscore = 4'd3; start = 1'b1; #1;
        total++; if (outs !== CLR) begin bad++; $display("FAIL start_clear got=%b want=%b", outs, CLR); end
        tick(); start = 1'b0; card_ack = 1'b1; #1;
        total++; if (outs !== (REQ | L_P1)) begin bad++; $display("FAIL nat_p1 got=%b want=%b", outs, REQ | L_P1); end
        tick(); #1;
        total++; if (outs !== (REQ | L_D1)) begin bad++; $display("FAIL nat_d1 got=%b want=%b", outs, REQ | L_D1); end
        tick(); #1;
        total++; if (outs !== (REQ | L_P2)) begin bad++; $display("FAIL nat_p2 got=%b want=%b", outs, REQ | L_P2); end
        tick(); #1;
        total++; if (outs !== (REQ | L_D2)) begin bad++; $display("FAIL nat_d2 got=%b want=%b", outs, REQ | L_D2); end
        tick(); #1;
        total++; if (outs !== 12'b0) begin bad++; $display("FAIL nat_check got=%b want=%b", outs, 12'b0); end
        tick(); #1;
        total++; if (outs !== 12'b0) begin bad++; $display("FAIL nat_score got=%b want=%b", outs, 12'b0); end
        card_ack = 1'b0;
        tick(); #1;
        total++; if (outs !== PW) begin bad++; $display("FAIL nat_show got=%b want=%b", outs, PW); end
        total++; if (cnt !== 5'b100_01) begin bad++; $display("FAIL nat_cnt got=%b want=%b", cnt, 5'b100_01); end
    endtask

    task automatic test_stall_tie();
        next_round = 1'b1; #1;
        total++; if (outs !== (PW | CLR)) begin bad++; $display("FAIL next_clear got=%b want=%b", outs, PW | CLR); end
        tick(); next_round = 1'b0; card_ack = 1'b1; #1;
        total++; if (outs !== (REQ | L_P1)) begin bad++; $display("FAIL r2_p1 got=%b want=%b", outs, REQ | L_P1); end
        tick(); card_ack = 1'b0; #1;
        for (int i = 0; i < 5; i++) begin
            total++; if (outs !== REQ) begin bad++; $display("FAIL stall_d1 cyc=%0d got=%b want=%b", i, outs, REQ); end
            tick();
        end
        card_ack = 1'b1; #1;
        total++; if (outs !== (REQ | L_D1)) begin bad++; $display("FAIL stall_release got=%b want=%b", outs, REQ | L_D1); end
        tick(); card_ack = 1'b0; #1;
        total++; if (outs !== REQ) begin bad++; $display("FAIL single_pulse got=%b want=%b", outs, REQ); end
        card_ack = 1'b1; #1;
        total++; if (outs !== (REQ | L_P2)) begin bad++; $display("FAIL r2_p2 got=%b want=%b", outs, REQ | L_P2); end
        pscore = 4'd6; dscore = 4'd6;
        tick(); tick(); card_ack = 1'b0;
        tick(); #1;
        total++; if (outs !== 12'b0) begin bad++; $display("FAIL tie_no_third got=%b want=%b", outs, 12'b0); end
        tick(); #1;
        total++; if (outs !== TL) begin bad++; $display("FAIL tie_light got=%b want=%b", outs, TL); end
        total++; if (cnt !== 5'b101_10) begin bad++; $display("FAIL tie_cnt got=%b want=%b", cnt, 5'b101_10); end
        next_round = 1'b1; #1;
        total++; if (outs !== TL) begin bad++; $display("FAIL final_no_clear got=%b want=%b", outs, TL); end
        tick(); next_round = 1'b0; #1;
        total++; if (outs !== (PW | MO)) begin bad++; $display("FAIL done_result got=%b want=%b", outs, PW | MO); end
        tick(); #1;
        total++; if (outs !== (PW | MO)) begin bad++; $display("FAIL done_hold got=%b want=%b", outs, PW | MO); end
    endtask

    task automatic test_new_match_done();
        new_match = 1'b1; #1;
        total++; if (outs !== (PW | MO | CLR)) begin bad++; $display("FAIL nm_done_clear got=%b want=%b", outs, PW | MO | CLR); end
        tick(); new_match = 1'b0; #1;
        total++; if (outs !== 12'b0) begin bad++; $display("FAIL nm_idle got=%b want=%b", outs, 12'b0); end
        total++; if (cnt !== 5'b0) begin bad++; $display("FAIL nm_cnt got=%b want=%b", cnt, 5'b0); end
    endtask

    task automatic test_third_card();
        pscore = 4'd4; dscore = 4'd3; pcard3 = 4'd8;
        begin_round(); deal4(); #1;
        total++; if (outs !== 12'b0) begin bad++; $display("FAIL tc_check got=%b want=%b", outs, 12'b0); end
        tick(); #1;
        total++; if (outs !== REQ) begin bad++; $display("FAIL tc_p3_req got=%b want=%b", outs, REQ); end
        card_ack = 1'b1; #1;
        total++; if (outs !== (REQ | L_P3)) begin bad++; $display("FAIL tc_p3_load got=%b want=%b", outs, REQ | L_P3); end
        tick(); #1;
        total++; if (outs !== 12'b0) begin bad++; $display("FAIL tc_bdec got=%b want=%b", outs, 12'b0); end
        tick(); card_ack = 1'b0; #1;
        total++; if (outs !== 12'b0) begin bad++; $display("FAIL tc_no_d3 got=%b want=%b", outs, 12'b0); end
        tick(); #1;
        total++; if (outs !== PW) begin bad++; $display("FAIL tc_show1 got=%b want=%b", outs, PW); end
        total++; if (cnt !== 5'b100_01) begin bad++; $display("FAIL tc_cnt1 got=%b want=%b", cnt, 5'b100_01); end
        next_round = 1'b1; tick(); next_round = 1'b0; pcard3 = 4'd7;
        deal4(); tick(); card_ack = 1'b1; tick(); card_ack = 1'b0; #1;
        total++; if (outs !== 12'b0) begin bad++; $display("FAIL tc_bdec2 got=%b want=%b", outs, 12'b0); end
        tick(); #1;
        total++; if (outs !== REQ) begin bad++; $display("FAIL tc_d3_req got=%b want=%b", outs, REQ); end
        card_ack = 1'b1; #1;
        total++; if (outs !== (REQ | L_D3)) begin bad++; $display("FAIL tc_d3_load got=%b want=%b", outs, REQ | L_D3); end
        tick(); card_ack = 1'b0; #1;
        total++; if (outs !== 12'b0) begin bad++; $display("FAIL tc_score2 got=%b want=%b", outs, 12'b0); end
        tick(); #1;
        total++; if (outs !== PW) begin bad++; $display("FAIL tc_show2 got=%b want=%b", outs, PW); end
        total++; if (cnt !== 5'b100_10) begin bad++; $display("FAIL tally_saturate got=%b want=%b", cnt, 5'b100_10); end
        next_round = 1'b1; tick(); next_round = 1'b0; #1;
        total++; if (outs !== (PW | MO)) begin bad++; $display("FAIL tc_done got=%b want=%b", outs, PW | MO); end
    endtask

    task automatic test_abort();
        new_match = 1'b1; tick(); new_match = 1'b0;
        pscore = 4'd9; dscore = 4'd0;
        begin_round(); deal4(); tick(); tick(); #1;
        total++; if (cnt !== 5'b100_01) begin bad++; $display("FAIL ab_pre_cnt got=%b want=%b", cnt, 5'b100_01); end
        next_round = 1'b1; tick(); next_round = 1'b0;
        card_ack = 1'b1; tick(); tick(); tick();
        new_match = 1'b1; #1;
        total++; if (outs !== (REQ | CLR)) begin bad++; $display("FAIL abort_no_load got=%b want=%b", outs, REQ | CLR); end
        tick(); new_match = 1'b0; #1;
        total++; if (outs !== 12'b0) begin bad++; $display("FAIL abort_idle got=%b want=%b", outs, 12'b0); end
        total++; if (cnt !== 5'b0) begin bad++; $display("FAIL abort_cnt got=%b want=%b", cnt, 5'b0); end
        tick(); #1;
        total++; if (outs !== 12'b0) begin bad++; $display("FAIL abort_stays got=%b want=%b", outs, 12'b0); end
        card_ack = 1'b0;
    endtask

    task automatic test_async_reset();
        pscore = 4'd9; dscore = 4'd0;
        begin_round(); deal4(); tick(); tick();
        next_round = 1'b1; tick(); next_round = 1'b0;
        pscore = 4'd4; dscore = 4'd3; pcard3 = 4'd8;
        deal4(); tick(); #1;
        total++; if (outs !== REQ) begin bad++; $display("FAIL pre_reset_p3 got=%b want=%b", outs, REQ); end
        total++; if (cnt !== 5'b100_01) begin bad++; $display("FAIL pre_reset_cnt got=%b want=%b", cnt, 5'b100_01); end
        resetb = 1'b1; #1;
        total++; if (outs !== 12'b0) begin bad++; $display("FAIL async_outs got=%b want=%b", outs, 12'b0); end
        total++; if (cnt !== 5'b0) begin bad++; $display("FAIL async_cnt got=%b want=%b", cnt, 5'b0); end
        tick(); resetb = 1'b0; #1;
        total++; if (outs !== 12'b0) begin bad++; $display("FAIL post_reset got=%b want=%b", outs, 12'b0); end
    endtask

    initial begin
        resetb = 1'b1; start = 1'b0; next_round = 1'b0; new_match = 1'b0;
        card_ack = 1'b0; pscore = 4'd0; dscore = 4'd0; pcard3 = 4'd0;
        test_reset();
        test_natural();
        test_stall_tie();
        test_new_match_done();
        test_third_card();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
